// File: rtl/br_seq_if.sv
// -----------------------------------------------------------------------------
// br_seq_if -- bundle of all br_seq channels except clock and reset.
//
// Signals
//   req_valid/req_ready, req_rs, req_rt : operand-read request channel
//   rsp_valid/rsp_ready, rsp_a, rsp_b   : operand response channel
//   wb_valid/wb_ready, wb_addr, wb_data : write-back request channel
//   ra1, ra2, wa, rw, din, dr1, dr2     : register-file port (dr1/dr2 are
//                                         combinational read data)
//   busy                                : sequencer activity flag
//
// Modports
//   slave  : the br_seq sequencer itself
//   master : the surrounding environment (requester, response sink,
//            write-back source and the register file)
// -----------------------------------------------------------------------------
interface br_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_rs;
  logic [4:0]  req_rt;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_a;
  logic [31:0] rsp_b;

  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [4:0]  wa;
  logic        rw;
  logic [31:0] din;
  logic [31:0] dr1;
  logic [31:0] dr2;

  logic        busy;

  modport slave (
    input  req_valid, req_rs, req_rt, rsp_ready, wb_valid, wb_addr, wb_data,
           dr1, dr2,
    output req_ready, rsp_valid, rsp_a, rsp_b, wb_ready, ra1, ra2, wa, rw,
           din, busy
  );

  modport master (
    output req_valid, req_rs, req_rt, rsp_ready, wb_valid, wb_addr, wb_data,
           dr1, dr2,
    input  req_ready, rsp_valid, rsp_a, rsp_b, wb_ready, ra1, ra2, wa, rw,
           din, busy
  );
endinterface

// File: rtl/br_seq.sv
// -----------------------------------------------------------------------------
// br_seq -- register-file read/write-back sequencer.
//
// Accepts operand-read requests (two register addresses), reads both operands
// from an external register file with combinational read data, and returns
// them on a response channel. Write-backs pass through a one-entry buffer and
// are committed to the register file whenever the read FSM is not in READ.
//
// Ports
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : br_seq_if.slave (request, response, write-back, reg-file, busy)
//
// Build option
//   BR_SEQ_ZERO_REG_EN : when defined, register 0 reads as zero and
//                        write-backs to address 0 are accepted but dropped.
//
// Read FSM
//   state | meaning
//   IDLE  | waiting for a read request; write buffer may drain
//   READ  | ra1/ra2 applied, operands captured at the edge leaving this state
//   HOLD  | response presented, waiting for rsp_ready
// -----------------------------------------------------------------------------
module br_seq (
  input  logic    clk,
  input  logic    rst_n,
  br_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;

  logic        wbuf_v_q, wbuf_v_d;
  logic [4:0]  wbuf_addr_q, wbuf_addr_d;
  logic [31:0] wbuf_data_q, wbuf_data_d;

  logic [4:0]  ra1_q, ra1_d;
  logic [4:0]  ra2_q, ra2_d;

  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_a_q, rsp_a_d;
  logic [31:0] rsp_b_q, rsp_b_d;

  // Set while a read has been waiting in IDLE; lets that read win over a
  // new write-back once the buffer is empty, so a write stream cannot
  // starve reads.
  logic        rd_pri_q, rd_pri_d;

  logic        req_ready;
  logic        wb_ready;
  logic        rw;
  logic        busy;
  logic        req_acc;
  logic        wb_acc;
  logic        rsp_hs;
  logic        wb_keep;
  logic [31:0] rd_a;
  logic [31:0] rd_b;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_acc) state_d = READ;
      READ:    state_d = HOLD;
      HOLD:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // A write-back offered together with a fresh read goes first, so the
    // read observes it; a read that has already waited takes priority.
    req_ready = (state_q == IDLE) && !wbuf_v_q && !(bus.wb_valid && !rd_pri_q);
    // Gated by rst_n so a buffered write is dropped at the reset edge.
    rw        = wbuf_v_q && (state_q != READ) && rst_n;
    // A waiting read lets the buffer drain but blocks its refill.
    wb_ready  = !wbuf_v_q || (rw && !((state_q == IDLE) && bus.req_valid));
    busy      = (state_q != IDLE) || wbuf_v_q;
  end

  assign req_acc = bus.req_valid && req_ready;
  assign wb_acc  = bus.wb_valid && wb_ready;
  assign rsp_hs  = rsp_valid_q && bus.rsp_ready;

`ifdef BR_SEQ_ZERO_REG_EN
  assign wb_keep = (bus.wb_addr != 5'd0);
  assign rd_a    = (ra1_q == 5'd0) ? 32'd0 : bus.dr1;
  assign rd_b    = (ra2_q == 5'd0) ? 32'd0 : bus.dr2;
`else
  assign wb_keep = 1'b1;
  assign rd_a    = bus.dr1;
  assign rd_b    = bus.dr2;
`endif

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    ra1_d       = ra1_q;
    ra2_d       = ra2_q;
    rsp_valid_d = rsp_valid_q;
    rsp_a_d     = rsp_a_q;
    rsp_b_d     = rsp_b_q;
    wbuf_v_d    = wbuf_v_q;
    wbuf_addr_d = wbuf_addr_q;
    wbuf_data_d = wbuf_data_q;
    rd_pri_d    = (state_q == IDLE) && bus.req_valid && !req_acc;

    if (req_acc) begin
      ra1_d = bus.req_rs;
      ra2_d = bus.req_rt;
    end

    if (state_q == READ) begin
      rsp_valid_d = 1'b1;
      rsp_a_d     = rd_a;
      rsp_b_d     = rd_b;
    end else if (rsp_hs) begin
      rsp_valid_d = 1'b0;
    end

    // Drain and reload can coincide; the reload wins.
    if (rw) begin
      wbuf_v_d = 1'b0;
    end
    if (wb_acc && wb_keep) begin
      wbuf_v_d    = 1'b1;
      wbuf_addr_d = bus.wb_addr;
      wbuf_data_d = bus.wb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ra1_q       <= 5'd0;
      ra2_q       <= 5'd0;
      rsp_valid_q <= 1'b0;
      rsp_a_q     <= 32'd0;
      rsp_b_q     <= 32'd0;
      wbuf_v_q    <= 1'b0;
      wbuf_addr_q <= 5'd0;
      wbuf_data_q <= 32'd0;
      rd_pri_q    <= 1'b0;
    end else begin
      ra1_q       <= ra1_d;
      ra2_q       <= ra2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_a_q     <= rsp_a_d;
      rsp_b_q     <= rsp_b_d;
      wbuf_v_q    <= wbuf_v_d;
      wbuf_addr_q <= wbuf_addr_d;
      wbuf_data_q <= wbuf_data_d;
      rd_pri_q    <= rd_pri_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Port drive
  // ---------------------------------------------------------------------------
  assign bus.req_ready = req_ready;
  assign bus.wb_ready  = wb_ready;
  assign bus.rw        = rw;
  assign bus.busy      = busy;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_a     = rsp_a_q;
  assign bus.rsp_b     = rsp_b_q;
  assign bus.ra1       = ra1_q;
  assign bus.ra2       = ra2_q;
  assign bus.wa        = wbuf_addr_q;
  assign bus.din       = wbuf_data_q;

endmodule

// File: tb/tb_br_seq.sv
// -----------------------------------------------------------------------------
// tb_br_seq -- self-checking bench for br_seq. Directed scenarios followed by
// randomized traffic checked against a register-level reference model.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_br_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  br_seq_if bus ();

  br_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Environment register file: combinational read, write on rw.
  logic [31:0] rf [32];
  assign bus.dr1 = rf[bus.ra1];
  assign bus.dr2 = rf[bus.ra2];
  always @(posedge clk) if (bus.rw) rf[bus.wa] <= bus.din;

  int errors = 0;
  int checks = 0;

  logic [31:0] b2b_d [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.req_rs    = 5'd0;
    bus.req_rt    = 5'd0;
    bus.rsp_ready = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.wb_addr   = 5'd0;
    bus.wb_data   = 32'd0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick(); tick();
    smp();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got=%0b exp=0", bus.rsp_valid); end
    checks++; if (bus.rw !== 1'b0) begin errors++; $display("FAIL rst_rw got=%0b exp=0", bus.rw); end
    checks++; if ({bus.rsp_a, bus.rsp_b} !== 64'd0) begin errors++; $display("FAIL rst_rsp_ab got=%h_%h exp=0", bus.rsp_a, bus.rsp_b); end
    checks++; if ({bus.ra1, bus.ra2, bus.wa} !== 15'd0) begin errors++; $display("FAIL rst_addr got=%0d/%0d/%0d exp=0", bus.ra1, bus.ra2, bus.wa); end
    checks++; if (bus.din !== 32'd0) begin errors++; $display("FAIL rst_din got=%h exp=0", bus.din); end
    tick();
    rst_n = 1'b1;
    smp();
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got=%0b exp=1", bus.req_ready); end
    checks++; if (bus.wb_ready !== 1'b1) begin errors++; $display("FAIL rst_wb_ready got=%0b exp=1", bus.wb_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0b exp=0", bus.busy); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_write_read();
    tick();
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h0000_00A5;
    smp();
    checks++; if (bus.wb_ready !== 1'b1) begin errors++; $display("FAIL wr_wb_ready got=%0b exp=1", bus.wb_ready); end
    tick();
    bus.wb_valid = 1'b0;
    smp();
    checks++; if ({bus.rw, bus.wa, bus.din} !== {1'b1, 5'd5, 32'hA5}) begin errors++; $display("FAIL wr_commit got rw=%0b wa=%0d din=%h exp rw=1 wa=5 din=a5", bus.rw, bus.wa, bus.din); end
    tick();
    smp();
    checks++; if (bus.rw !== 1'b0) begin errors++; $display("FAIL wr_one_cycle got rw=%0b exp=0", bus.rw); end
    tick();
    bus.req_valid = 1'b1; bus.req_rs = 5'd5; bus.req_rt = 5'd5;
    smp();
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rd_req_ready got=%0b exp=1", bus.req_ready); end
    tick();
    bus.req_valid = 1'b0;
    smp();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_lat1 got rsp_valid=%0b exp=0", bus.rsp_valid); end
    tick();
    bus.rsp_ready = 1'b1;
    smp();
    checks++; if ({bus.rsp_valid, bus.rsp_a, bus.rsp_b} !== {1'b1, 32'hA5, 32'hA5}) begin errors++; $display("FAIL rd_lat2 got v=%0b a=%h b=%h exp v=1 a=a5 b=a5", bus.rsp_valid, bus.rsp_a, bus.rsp_b); end
    tick();
    bus.rsp_ready = 1'b0;
    smp();
    checks++; if ({bus.rsp_valid, bus.busy} !== 2'b00) begin errors++; $display("FAIL rd_done got v=%0b busy=%0b exp 0/0", bus.rsp_valid, bus.busy); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_priority();
    tick();
    bus.req_valid = 1'b1; bus.req_rs = 5'd3; bus.req_rt = 5'd3;
    bus.wb_valid  = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h33;
    smp();
    checks++; if ({bus.req_ready, bus.wb_ready} !== 2'b01) begin errors++; $display("FAIL pri_first got req_ready=%0b wb_ready=%0b exp 0/1", bus.req_ready, bus.wb_ready); end
    tick();
    bus.wb_valid = 1'b0;
    smp();
    checks++; if ({bus.rw, bus.wa, bus.req_ready, bus.wb_ready} !== {1'b1, 5'd3, 1'b0, 1'b0}) begin errors++; $display("FAIL pri_drain got rw=%0b wa=%0d req_ready=%0b wb_ready=%0b exp 1/3/0/0", bus.rw, bus.wa, bus.req_ready, bus.wb_ready); end
    tick();
    smp();
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL pri_accept got req_ready=%0b exp=1", bus.req_ready); end
    tick();
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    smp();
    tick();
    smp();
    checks++; if ({bus.rsp_valid, bus.rsp_a, bus.rsp_b} !== {1'b1, 32'h33, 32'h33}) begin errors++; $display("FAIL pri_rsp got v=%0b a=%h b=%h exp v=1 a=33 b=33", bus.rsp_valid, bus.rsp_a, bus.rsp_b); end
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      tick();
      b2b_d[i]     = $urandom;
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 5'(i + 1);
      bus.wb_data  = b2b_d[i];
      smp();
      checks++; if (bus.wb_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got=%0b exp=1", i, bus.wb_ready); end
      if (i > 0) begin
        checks++; if ({bus.rw, bus.wa, bus.din} !== {1'b1, 5'(i), b2b_d[i-1]}) begin errors++; $display("FAIL b2b_write[%0d] got rw=%0b wa=%0d din=%h exp rw=1 wa=%0d din=%h", i, bus.rw, bus.wa, bus.din, i, b2b_d[i-1]); end
      end
    end
    tick();
    bus.wb_valid = 1'b0;
    smp();
    checks++; if ({bus.rw, bus.wa, bus.din} !== {1'b1, 5'd4, b2b_d[3]}) begin errors++; $display("FAIL b2b_last got rw=%0b wa=%0d din=%h exp rw=1 wa=4 din=%h", bus.rw, bus.wa, bus.din, b2b_d[3]); end
    tick();
    smp();
    checks++; if (bus.rw !== 1'b0) begin errors++; $display("FAIL b2b_end got rw=%0b exp=0", bus.rw); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_hold();
    logic [31:0] d9;
    d9 = $urandom;
    tick();
    bus.req_valid = 1'b1; bus.req_rs = 5'd1; bus.req_rt = 5'd2;
    bus.rsp_ready = 1'b0;
    smp();
    tick();
    bus.req_valid = 1'b0;
    smp();
    tick();
    smp();
    checks++; if ({bus.rsp_valid, bus.rsp_a, bus.rsp_b} !== {1'b1, b2b_d[0], b2b_d[1]}) begin errors++; $display("FAIL hold_rsp got v=%0b a=%h b=%h exp v=1 a=%h b=%h", bus.rsp_valid, bus.rsp_a, bus.rsp_b, b2b_d[0], b2b_d[1]); end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 1) begin bus.wb_valid = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = d9; end
      if (i == 2) bus.wb_valid = 1'b0;
      smp();
      checks++; if ({bus.rsp_valid, bus.rsp_a, bus.rsp_b, bus.req_ready} !== {1'b1, b2b_d[0], b2b_d[1], 1'b0}) begin errors++; $display("FAIL hold_stable[%0d] got v=%0b a=%h b=%h req_ready=%0b", i, bus.rsp_valid, bus.rsp_a, bus.rsp_b, bus.req_ready); end
      if (i == 1) begin
        checks++; if (bus.wb_ready !== 1'b1) begin errors++; $display("FAIL hold_wb_ready got=%0b exp=1", bus.wb_ready); end
      end
      if (i == 2) begin
        checks++; if ({bus.rw, bus.wa, bus.din} !== {1'b1, 5'd9, d9}) begin errors++; $display("FAIL hold_write got rw=%0b wa=%0d din=%h exp rw=1 wa=9 din=%h", bus.rw, bus.wa, bus.din, d9); end
      end
    end
    tick();
    bus.rsp_ready = 1'b1;
    smp();
    tick();
    bus.rsp_ready = 1'b0;
    smp();
    checks++; if ({bus.rsp_valid, bus.busy} !== 2'b00) begin errors++; $display("FAIL hold_done got v=%0b busy=%0b exp 0/0", bus.rsp_valid, bus.busy); end
    checks++; if (rf[9] !== d9) begin errors++; $display("FAIL hold_commit got rf9=%h exp=%h", rf[9], d9); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    logic [31:0] old7;
    old7 = rf[7];
    tick();
    bus.req_valid = 1'b1; bus.req_rs = 5'd1; bus.req_rt = 5'd1;
    smp();
    tick();
    bus.req_valid = 1'b0;
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = ~old7;
    smp();
    checks++; if (bus.wb_ready !== 1'b1) begin errors++; $display("FAIL rmid_wb_ready got=%0b exp=1", bus.wb_ready); end
    tick();
    bus.wb_valid = 1'b0;
    rst_n = 1'b0;
    smp();
    checks++; if ({bus.rsp_valid, bus.rw} !== 2'b10) begin errors++; $display("FAIL rmid_pre got v=%0b rw=%0b exp 1/0", bus.rsp_valid, bus.rw); end
    tick();
    rst_n = 1'b1;
    smp();
    checks++; if ({bus.rsp_valid, bus.rw, bus.busy, bus.req_ready} !== 4'b0001) begin errors++; $display("FAIL rmid_post got v=%0b rw=%0b busy=%0b req_ready=%0b exp 0/0/0/1", bus.rsp_valid, bus.rw, bus.busy, bus.req_ready); end
    checks++; if (rf[7] !== old7) begin errors++; $display("FAIL rmid_discard got rf7=%h exp=%h", rf[7], old7); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_zero_reg();
    logic        rw_seen;
    logic [31:0] exp0;
`ifdef BR_SEQ_ZERO_REG_EN
    exp0 = 32'd0;
`else
    exp0 = 32'hFFFF_FFFF;
`endif
    rw_seen = 1'b0;
    tick();
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFF_FFFF;
    smp();
    checks++; if (bus.wb_ready !== 1'b1) begin errors++; $display("FAIL zero_wb_ready got=%0b exp=1", bus.wb_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.wb_valid = 1'b0;
      smp();
      if (bus.rw === 1'b1 && bus.wa === 5'd0) rw_seen = 1'b1;
    end
`ifdef BR_SEQ_ZERO_REG_EN
    checks++; if (rw_seen !== 1'b0) begin errors++; $display("FAIL zero_rw got write=1 exp=0"); end
`else
    checks++; if (rw_seen !== 1'b1) begin errors++; $display("FAIL zero_rw got write=0 exp=1"); end
`endif
    tick();
    bus.req_valid = 1'b1; bus.req_rs = 5'd0; bus.req_rt = 5'd0;
    bus.rsp_ready = 1'b1;
    smp();
    tick();
    bus.req_valid = 1'b0;
    smp();
    tick();
    smp();
    checks++; if ({bus.rsp_valid, bus.rsp_a, bus.rsp_b} !== {1'b1, exp0, exp0}) begin errors++; $display("FAIL zero_read got v=%0b a=%h b=%h exp v=1 a=%h b=%h", bus.rsp_valid, bus.rsp_a, bus.rsp_b, exp0, exp0); end
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: architectural register contents as seen by reads.
  logic [31:0] shadow [32];

  function automatic logic [31:0] model_read(input logic [4:0] a);
`ifdef BR_SEQ_ZERO_REG_EN
    if (a == 5'd0) return 32'd0;
`endif
    return shadow[a];
  endfunction

  function automatic logic model_keeps(input logic [4:0] a);
`ifdef BR_SEQ_ZERO_REG_EN
    return a != 5'd0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic test_random();
    logic [31:0] ea [$];
    logic [31:0] eb [$];
    logic [4:0]  wq_a [$];
    logic [31:0] wq_d [$];
    logic        rd_acc, wb_acc, rsp_hs, w_fire, rd_out;
    int          age, rd_wait, n_cyc;
    n_cyc   = 600;
    rd_acc  = 1'b0;
    wb_acc  = 1'b0;
    rd_out  = 1'b0;
    age     = 100;
    rd_wait = 0;
    for (int i = 0; i < 32; i++) shadow[i] = rf[i];
    idle_inputs();
    for (int c = 0; c < n_cyc; c++) begin
      tick();
      if (rd_acc || !bus.req_valid) begin
        bus.req_valid = (c < n_cyc - 30) && ($urandom_range(0, 2) == 0);
        bus.req_rs    = 5'($urandom_range(0, 7));
        bus.req_rt    = 5'($urandom_range(0, 7));
      end
      if (wb_acc || !bus.wb_valid) begin
        bus.wb_valid = (c < n_cyc - 30) && ($urandom_range(0, 1) == 0);
        bus.wb_addr  = 5'($urandom_range(0, 7));
        bus.wb_data  = $urandom;
      end
      bus.rsp_ready = (c >= n_cyc - 30) || ($urandom_range(0, 1) == 0);
      smp();
      age++;
      checks++; if (bus.busy !== (rd_out || wq_a.size() != 0)) begin errors++; $display("FAIL rnd_busy c=%0d got=%0b exp=%0b", c, bus.busy, rd_out || wq_a.size() != 0); end
      if (age == 1) begin
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rnd_lat1 c=%0d got rsp_valid=%0b exp=0", c, bus.rsp_valid); end
      end
      if (age == 2) begin
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL rnd_lat2 c=%0d got rsp_valid=%0b exp=1", c, bus.rsp_valid); end
      end
      if (bus.rsp_valid === 1'b1) begin
        checks++;
        if (ea.size() == 0) begin errors++; $display("FAIL rnd_rsp_unexp c=%0d got a=%h b=%h exp none", c, bus.rsp_a, bus.rsp_b); end
        else if ({bus.rsp_a, bus.rsp_b} !== {ea[0], eb[0]}) begin errors++; $display("FAIL rnd_rsp c=%0d got a=%h b=%h exp a=%h b=%h", c, bus.rsp_a, bus.rsp_b, ea[0], eb[0]); end
      end
      if (bus.rw === 1'b1) begin
        checks++;
        if (wq_a.size() == 0) begin errors++; $display("FAIL rnd_wr_unexp c=%0d got wa=%0d din=%h exp none", c, bus.wa, bus.din); end
        else if ({bus.wa, bus.din} !== {wq_a[0], wq_d[0]}) begin errors++; $display("FAIL rnd_wr c=%0d got wa=%0d din=%h exp wa=%0d din=%h", c, bus.wa, bus.din, wq_a[0], wq_d[0]); end
      end
      rd_acc = bus.req_valid && bus.req_ready;
      wb_acc = bus.wb_valid && bus.wb_ready;
      rsp_hs = bus.rsp_valid && bus.rsp_ready;
      w_fire = bus.rw;
      if (bus.req_valid && !rd_acc) rd_wait++; else rd_wait = 0;
      if (rd_wait > 64) begin
        checks++; errors++;
        $display("FAIL rnd_starve c=%0d got wait=%0d exp<=64", c, rd_wait);
        rd_wait = 0;
      end
      if (w_fire === 1'b1 && wq_a.size() != 0) begin
        void'(wq_a.pop_front());
        void'(wq_d.pop_front());
      end
      if (rsp_hs === 1'b1 && ea.size() != 0) begin
        void'(ea.pop_front());
        void'(eb.pop_front());
        rd_out = 1'b0;
      end
      if (rd_acc === 1'b1) begin
        ea.push_back(model_read(bus.req_rs));
        eb.push_back(model_read(bus.req_rt));
        rd_out = 1'b1;
        age    = 0;
      end
      if (wb_acc === 1'b1 && model_keeps(bus.wb_addr)) begin
        wq_a.push_back(bus.wb_addr);
        wq_d.push_back(bus.wb_data);
        shadow[bus.wb_addr] = bus.wb_data;
      end
    end
    checks++; if (ea.size() != 0 || wq_a.size() != 0) begin errors++; $display("FAIL rnd_drain got rsp_left=%0d wr_left=%0d exp 0/0", ea.size(), wq_a.size()); end
    for (int i = 1; i < 8; i++) begin
      checks++; if (rf[i] !== shadow[i]) begin errors++; $display("FAIL rnd_rf[%0d] got=%h exp=%h", i, rf[i], shadow[i]); end
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    test_reset();
    test_write_read();
    test_priority();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_zero_reg();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
